// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch sequencer: state encoding, F/D slot struct and helpers.
// FETCH_MISALIGN_EN selects whether misaligned redirect targets become fault slots.
package fetch_ctrl_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_FLUSH} fetch_state_t;

  localparam u64 PC_RESET  = 64'h0000_0000_8000_0000;
  localparam u32 NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    u1  valid;
    u64 pc;
    u32 instr;
    u1  misalign;
  } fetch_data_t;

`ifdef FETCH_MISALIGN_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  function automatic u1 is_misaligned(input logic [1:0] lo);
    return MISALIGN_EN && (lo != 2'b00);
  endfunction

  // Fault slot handed to decode in place of a fetched instruction.
  function automatic fetch_data_t fault_slot(input u64 a);
    return '{valid: 1'b1, pc: a, instr: NOP_INSTR, misalign: 1'b1};
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch PC owner and instruction-bus sequencer feeding the F/D register.
// Optional FETCH_MISALIGN_EN turns misaligned redirect targets into fault slots.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter u64 RESET_PC = PC_RESET,
  parameter u64 PC_STEP  = 64'd4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_misalign,
  output logic        stall_i
);

  fetch_state_t state_q, state_d;
  u64           pc_q, pc_d;
  u64           req_q, req_d;
  fetch_data_t  f_q, f_d;
  u64           flush_tgt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      req_q   <= RESET_PC;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      f_q     <= f_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    f_d       = f_q;
    flush_tgt = redirect ? redirect_pc : pc_q;
    unique case (state_q)
      S_REQ: begin
        if (iresp_data_ok) begin
          if (redirect) begin
            // Response arrived for a now-stale address: drop it.
            pc_d = redirect_pc;
            if (is_misaligned(redirect_pc[1:0])) begin
              f_d     = fault_slot(redirect_pc);
              state_d = S_HOLD;
            end else begin
              req_d = redirect_pc;
            end
          end else begin
            f_d     = '{valid: 1'b1, pc: req_q, instr: iresp_data, misalign: 1'b0};
            pc_d    = req_q + PC_STEP;
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_FLUSH;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d = redirect_pc;
          if (is_misaligned(redirect_pc[1:0])) begin
            f_d = fault_slot(redirect_pc);
          end else begin
            f_d.valid    = 1'b0;
            f_d.misalign = 1'b0;
            req_d        = redirect_pc;
            state_d      = S_REQ;
          end
        end else if (!stall && f_q.valid) begin
          f_d.valid    = 1'b0;
          f_d.misalign = 1'b0;
          // An accepted fault slot parks the front end until the next redirect.
          if (!f_q.misalign) begin
            req_d   = pc_q;
            state_d = S_REQ;
          end
        end
      end
      S_FLUSH: begin
        if (redirect) pc_d = redirect_pc;
        if (iresp_data_ok) begin
          if (is_misaligned(flush_tgt[1:0])) begin
            f_d     = fault_slot(flush_tgt);
            state_d = S_HOLD;
          end else begin
            req_d   = flush_tgt;
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Gating with resetn keeps the bus quiet for the whole reset window.
  assign ireq_valid = resetn && (state_q != S_HOLD);
  assign ireq_addr  = req_q;
  assign stall_i    = (state_q != S_HOLD);
  assign f_valid    = f_q.valid;
  assign f_pc       = f_q.pc;
  assign f_instr    = f_q.instr;
  assign f_misalign = MISALIGN_EN & f_q.misalign;

endmodule
